dmem_arbiter: RTL

- Two-port arbiter and sequencer in front of the single-port data memory (8-bit word address, 32-bit data, synchronous write, combinational read).
- Requester 0 is the core load/store unit; requester 1 is the debug/DMA loader.
- Requester 0 wins the first tie; round-robin after that.
- Supports a lock for atomic read-then-write (ARM SWP).
- Registers every memory access, giving a fixed, glitch-free memory-port timing.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_arbiter_rr_pick2.sv | 53 +++++
 rtl/dmem_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory arbiter slice.
//   - AW_DEF / DW_DEF : default memory word-address and data widths
//   - state_t         : sequencer states (IDLE -> ACCESS -> RESP -> IDLE)
//   - req_id_t        : requester identifier (0 = core LSU, 1 = debug/DMA)
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage : dmem_pkg

// File: rtl/dmem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
//   Combinational two-way round-robin picker with lock override.
//   Ports:
//     valid[1:0]  in  : request present per requester
//     last_grant  in  : requester granted most recently
//     lock_held   in  : an atomic sequence is in progress
//     lock_owner  in  : requester owning the lock
//     gnt_valid   out : a requester can be granted now
//     gnt_id      out : which requester is granted
// -----------------------------------------------------------------------------
module rr_pick2
    import dmem_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    input  logic       lock_held,
    input  req_id_t    lock_owner,
    output logic       gnt_valid,
    output req_id_t    gnt_id
);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (lock_held) begin
            // The lock owner keeps the memory even when it is momentarily
            // idle; the other requester simply waits.
            gnt_valid = valid[lock_owner];
            gnt_id    = lock_owner;
        end else begin
            case (valid)
                2'b01: begin
                    gnt_valid = 1'b1;
                    gnt_id    = 1'b0;
                end
                2'b10: begin
                    gnt_valid = 1'b1;
                    gnt_id    = 1'b1;
                end
                2'b11: begin
                    gnt_valid = 1'b1;
                    gnt_id    = ~last_grant;
                end
                default: begin
                    gnt_valid = 1'b0;
                    gnt_id    = 1'b0;
                end
            endcase
        end
    end

endmodule : rr_pick2

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Arbitrates two requesters onto a single-port data memory (synchronous
//   write, combinational read) and sequences each access through
//   IDLE -> ACCESS -> RESP, so the memory port is always driven from flops.
//   Supports a lock that keeps ownership across a read-then-write pair.
//   Ports:
//     clk, rst                   : clock, asynchronous active-high reset
//     rX_valid/ready             : request handshake (ready only in IDLE)
//     rX_we/lock/addr/wdata      : request payload, held stable until ready
//     rX_rsp_valid/rX_rdata      : one-cycle response pulse, read data (old
//                                  contents for a write), held until the
//                                  next response to the same requester
//     mem_we/addr/wdata/rdata    : memory port (registered outputs)
//     grant_id                   : requester owning the current access
//     busy                       : sequencer not in IDLE
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic          r0_we,
    input  logic          r0_lock,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_rsp_valid,
    output logic [DW-1:0] r0_rdata,

    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic          r1_we,
    input  logic          r1_lock,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_rsp_valid,
    output logic [DW-1:0] r1_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          grant_id,
    output logic          busy
);

    state_t        state_q, state_d;
    req_id_t       grant_id_q, grant_id_d;
    req_id_t       last_grant_q, last_grant_d;
    logic          lock_held_q, lock_held_d;
    req_id_t       lock_owner_q, lock_owner_d;
    logic          busy_q, busy_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic          gnt_valid;
    req_id_t       gnt_id;
    logic          accept;
    logic          sel_we;
    logic          sel_lock;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_pick2 u_pick (
        .valid      ({r1_valid, r0_valid}),
        .last_grant (last_grant_q),
        .lock_held  (lock_held_q),
        .lock_owner (lock_owner_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign accept   = (state_q == IDLE) && gnt_valid;
    assign r0_ready = accept && (gnt_id == 1'b0);
    assign r1_ready = accept && (gnt_id == 1'b1);

    assign sel_we    = gnt_id ? r1_we    : r0_we;
    assign sel_lock  = gnt_id ? r1_lock  : r0_lock;
    assign sel_addr  = gnt_id ? r1_addr  : r0_addr;
    assign sel_wdata = gnt_id ? r1_wdata : r0_wdata;

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        lock_held_d  = lock_held_q;
        lock_owner_d = lock_owner_q;
        mem_we_d     = 1'b0;          // only ever high for the ACCESS cycle
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // The request is latched straight into the memory-port
                    // flops so ACCESS drives the memory glitch-free.
                    state_d      = ACCESS;
                    grant_id_d   = gnt_id;
                    last_grant_d = gnt_id;
                    lock_held_d  = sel_lock;
                    lock_owner_d = gnt_id;
                    mem_we_d     = sel_we;
                    mem_addr_d   = sel_addr;
                    mem_wdata_d  = sel_wdata;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;   // makes requester 0 win the first tie
            lock_held_q  <= 1'b0;
            lock_owner_q <= 1'b0;
            busy_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            lock_held_q  <= lock_held_d;
            lock_owner_q <= lock_owner_d;
            busy_q       <= busy_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Per-requester response path. Read data is captured at the end of
    // ACCESS, i.e. on the same edge the write lands, so a write returns the
    // old contents.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic          rsp_valid_q, rsp_valid_d;
        logic [DW-1:0] rdata_q, rdata_d;
        logic          mine;

        assign mine = (state_q == ACCESS) && (grant_id_q == req_id_t'(gi));

        always_comb begin
            rsp_valid_d = mine;
            rdata_d     = rdata_q;
            if (mine) begin
                rdata_d = mem_rdata;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rsp_valid_q <= 1'b0;
                rdata_q     <= '0;
            end else begin
                rsp_valid_q <= rsp_valid_d;
                rdata_q     <= rdata_d;
            end
        end

        if (gi == 0) begin : g_r0
            assign r0_rsp_valid = rsp_valid_q;
            assign r0_rdata     = rdata_q;
        end else begin : g_r1
            assign r1_rsp_valid = rsp_valid_q;
            assign r1_rdata     = rdata_q;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;

endmodule : dmem_arbiter
